// File: rtl/sdram_cmd_responder.sv
// SDRAM device emulator: decodes controller commands, tracks open banks and the mode
// register, and serves bursts from a small on-chip RAM at the programmed CAS latency.
module sdram_cmd_responder #(
    parameter int unsigned ROW_BITS = 2,
    parameter int unsigned COL_BITS = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sdram_cke,
    input  logic        sdram_cs_n,
    input  logic        sdram_ras_n,
    input  logic        sdram_cas_n,
    input  logic        sdram_we_n,
    input  logic [1:0]  sdram_ba,
    input  logic [12:0] sdram_addr,
    input  logic [1:0]  sdram_dqm,
    input  logic [15:0] dq_in,
    output logic [15:0] dq_out,
    output logic        dq_oe,
    output logic        mode_done,
    output logic [3:0]  err_flags
);
    localparam int unsigned AddrW = 2 + ROW_BITS + COL_BITS;
    localparam int unsigned Depth = 1 << AddrW;

    typedef enum logic [1:0] {StIdle, StWburst, StRburst} state_e;

    state_e              state_q, state_d;
    logic [3:0]          open_q, open_d;
    logic [ROW_BITS-1:0] row_q [4];
    logic [ROW_BITS-1:0] row_d [4];
    logic [1:0]          cl_q, cl_d;
    logic [8:0]          mask_q, mask_d;
    logic                mode_done_q, mode_done_d;
    logic [2:0]          err_q, err_d;
    logic [1:0]          bank_q, bank_d;
    logic [8:0]          col_q, col_d;
    logic [8:0]          cnt_q, cnt_d;
    logic                ap_q, ap_d;

    logic [3:0]  cmd;
    logic        cmd_act, cmd_rd, cmd_wr, cmd_pre, cmd_mrs, cmd_bst;
    logic        rw_ok, flush;
    logic        beat, beat_wr;
    logic [1:0]  beat_bank;
    logic [8:0]  beat_col;
    logic [AddrW-1:0] ram_idx;

    logic [15:0] mem [Depth];
    logic [15:0] ram_q, d1_q, out_q;
    logic        v0_q, v1_q, oe_q;

    logic unused_bits;
    assign unused_bits = ^{sdram_addr, beat_col};

    assign cmd     = {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n};
    assign cmd_act = sdram_cke && (cmd == 4'b0011);
    assign cmd_rd  = sdram_cke && (cmd == 4'b0101);
    assign cmd_wr  = sdram_cke && (cmd == 4'b0100);
    assign cmd_pre = sdram_cke && (cmd == 4'b0010);
    assign cmd_mrs = sdram_cke && (cmd == 4'b0000);
    assign cmd_bst = sdram_cke && (cmd == 4'b0110);
    assign rw_ok   = (cmd_rd || cmd_wr) && open_q[sdram_ba];
    assign flush   = rw_ok && cmd_wr && (state_q == StRburst);

    // Next column wraps inside the BL-aligned block selected by mask.
    function automatic logic [8:0] next_col(input logic [8:0] c, input logic [8:0] m);
        return (c & ~m) | ((c + 9'd1) & m);
    endfunction

    always_comb begin
        state_d     = state_q;
        open_d      = open_q;
        row_d       = row_q;
        cl_d        = cl_q;
        mask_d      = mask_q;
        mode_done_d = mode_done_q;
        err_d       = err_q;
        bank_d      = bank_q;
        col_d       = col_q;
        cnt_d       = cnt_q;
        ap_d        = ap_q;
        beat        = 1'b0;
        beat_wr     = 1'b0;
        beat_bank   = bank_q;
        beat_col    = col_q;

        if (rw_ok) begin
            beat      = 1'b1;
            beat_wr   = cmd_wr;
            beat_bank = sdram_ba;
            beat_col  = sdram_addr[8:0];
            bank_d    = sdram_ba;
            ap_d      = sdram_addr[10];
            if (mask_q == 9'd0) begin
                state_d = StIdle;
                if (sdram_addr[10]) open_d[sdram_ba] = 1'b0;
            end else begin
                state_d = cmd_wr ? StWburst : StRburst;
                col_d   = next_col(sdram_addr[8:0], mask_q);
                cnt_d   = mask_q;
            end
        end else if (sdram_cke && state_q != StIdle) begin
            if (cmd_bst || (cmd_pre && (sdram_addr[10] || sdram_ba == bank_q))) begin
                state_d = StIdle;
            end else begin
                beat    = 1'b1;
                beat_wr = (state_q == StWburst);
                col_d   = next_col(col_q, mask_q);
                cnt_d   = cnt_q - 9'd1;
                if (cnt_q == 9'd1) begin
                    state_d = StIdle;
                    if (ap_q) open_d[bank_q] = 1'b0;
                end
            end
        end

        // Explicit bank commands take precedence over a closing auto-precharge.
        if (cmd_act) begin
            open_d[sdram_ba] = 1'b1;
            row_d[sdram_ba]  = sdram_addr[ROW_BITS-1:0];
        end
        if (cmd_pre) begin
            if (sdram_addr[10]) open_d = 4'b0000;
            else                open_d[sdram_ba] = 1'b0;
        end

        if (cmd_mrs) begin
            mode_done_d = 1'b1;
            case (sdram_addr[2:0])
                3'b000:  mask_d = 9'd0;
                3'b001:  mask_d = 9'd1;
                3'b010:  mask_d = 9'd3;
                3'b011:  mask_d = 9'd7;
                3'b111:  mask_d = 9'd511;
                default: mask_d = mask_q;
            endcase
            if (sdram_addr[6:4] == 3'b010)      cl_d = 2'd2;
            else if (sdram_addr[6:4] == 3'b011) cl_d = 2'd3;
        end

        if ((cmd_rd || cmd_wr) && !open_q[sdram_ba])             err_d[0] = 1'b1;
        if (cmd_act && open_q[sdram_ba])                         err_d[1] = 1'b1;
        if ((cmd_rd || cmd_wr || cmd_act) && !mode_done_q)       err_d[2] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            open_q      <= 4'b0000;
            row_q       <= '{default: '0};
            cl_q        <= 2'd3;
            mask_q      <= 9'd0;
            mode_done_q <= 1'b0;
            err_q       <= 3'b000;
            bank_q      <= 2'd0;
            col_q       <= 9'd0;
            cnt_q       <= 9'd0;
            ap_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            open_q      <= open_d;
            row_q       <= row_d;
            cl_q        <= cl_d;
            mask_q      <= mask_d;
            mode_done_q <= mode_done_d;
            err_q       <= err_d;
            bank_q      <= bank_d;
            col_q       <= col_d;
            cnt_q       <= cnt_d;
            ap_q        <= ap_d;
        end
    end

    assign ram_idx = {beat_bank, row_q[beat_bank], beat_col[COL_BITS-1:0]};

    always_ff @(posedge clk) begin
        if (beat) begin
            if (beat_wr) begin
                if (!sdram_dqm[0]) mem[ram_idx][7:0]  <= dq_in[7:0];
                if (!sdram_dqm[1]) mem[ram_idx][15:8] <= dq_in[15:8];
            end else begin
                ram_q <= mem[ram_idx];
            end
        end
    end

    // Registered RAM read followed by CL-1 stages; the output register is the last stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            v0_q  <= 1'b0;
            v1_q  <= 1'b0;
            d1_q  <= 16'h0000;
            oe_q  <= 1'b0;
            out_q <= 16'h0000;
        end else if (sdram_cke) begin
            if (flush) begin
                v0_q <= 1'b0;
                v1_q <= 1'b0;
                oe_q <= 1'b0;
            end else begin
                v0_q <= beat && !beat_wr;
                v1_q <= v0_q;
                d1_q <= ram_q;
                if (cl_q == 2'd2) begin
                    oe_q <= v0_q;
                    if (v0_q) out_q <= ram_q;
                end else begin
                    oe_q <= v1_q;
                    if (v1_q) out_q <= d1_q;
                end
            end
        end
    end

    assign dq_out    = out_q;
    assign dq_oe     = oe_q && !flush;
    assign mode_done = mode_done_q;
    assign err_flags = {1'b0, err_q};

endmodule

// File: tb/tb_sdram_cmd_responder.sv
// Self-checking bench: read beats are queued with their expected data and arrival tick
// (count of clock edges with cke high) and matched against the DUT output.
module tb_sdram_cmd_responder;
    logic        clk = 1'b0;
    logic        rst, cke, cs_n, ras_n, cas_n, we_n;
    logic [1:0]  ba, dqm;
    logic [12:0] addr;
    logic [15:0] dq_in, dq_out;
    logic        dq_oe, mode_done;
    logic [3:0]  err_flags;

    localparam logic [3:0] CNop = 4'b0111, CAct = 4'b0011, CRd = 4'b0101, CWr = 4'b0100;
    localparam logic [3:0] CMrs = 4'b0000, CBst = 4'b0110;

    typedef struct {int t; logic [15:0] d;} beat_t;
    beat_t exp_q[$];
    beat_t b;
    int    n_cmp = 0, n_bad = 0;
    int    tick = 0;
    int    cl = 3;
    logic  adv = 1'b0;
    logic [15:0] dat [8];

    sdram_cmd_responder #(.ROW_BITS(2), .COL_BITS(6)) dut (
        .clk(clk), .rst(rst), .sdram_cke(cke), .sdram_cs_n(cs_n), .sdram_ras_n(ras_n),
        .sdram_cas_n(cas_n), .sdram_we_n(we_n), .sdram_ba(ba), .sdram_addr(addr),
        .sdram_dqm(dqm), .dq_in(dq_in), .dq_out(dq_out), .dq_oe(dq_oe),
        .mode_done(mode_done), .err_flags(err_flags)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) begin
        adv  <= cke && !rst;
        tick <= tick + (cke ? 1 : 0);
    end

    always @(negedge clk) begin
        if (adv) begin
            if (dq_oe) begin
                if (exp_q.size() == 0) begin
                    check_eq("extra_beat", {31'd0, dq_oe}, 32'd0);
                end else begin
                    b = exp_q.pop_front();
                    check_eq("beat_data", {16'd0, dq_out}, {16'd0, b.d});
                    check_eq("beat_time", tick, b.t);
                end
            end else if (exp_q.size() > 0 && exp_q[0].t <= tick) begin
                b = exp_q.pop_front();
                check_eq("beat_missing", {31'd0, dq_oe}, 32'd1);
            end
        end
    end

    task automatic drive(input logic [3:0] c, input logic [1:0] bk, input logic [12:0] a,
                         input logic [15:0] d, input logic [1:0] m);
        {cs_n, ras_n, cas_n, we_n} = c;
        ba = bk; addr = a; dq_in = d; dqm = m;
        @(posedge clk);
        #1;
        {cs_n, ras_n, cas_n, we_n} = CNop;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Expect beat i of a command issued now at tick + cl + i.
    task automatic expect_beat(input int i, input logic [15:0] d);
        beat_t e;
        e.t = tick + cl + i;
        e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cl  = 3;
    endtask

    initial begin
        rst = 1'b1; cke = 1'b1; {cs_n, ras_n, cas_n, we_n} = CNop;
        ba = 2'd0; addr = 13'd0; dqm = 2'b00; dq_in = 16'h0000;
        for (int i = 0; i < 8; i++) dat[i] = 16'h5000 + 16'(i);
        do_reset();
        check_eq("rst_oe", {31'd0, dq_oe}, 32'd0);
        check_eq("rst_dq", {16'd0, dq_out}, 32'd0);
        check_eq("rst_mode", {31'd0, mode_done}, 32'd0);
        check_eq("rst_err", {28'd0, err_flags}, 32'd0);

        // CL3 BL4 write then read
        drive(CMrs, 2'd0, 13'h032, 16'h0, 2'b00);
        drive(CAct, 2'd1, 13'd2, 16'h0, 2'b00);
        drive(CWr, 2'd1, 13'd8, 16'h1111, 2'b00);
        drive(CNop, 2'd0, 13'd0, 16'h2222, 2'b00);
        drive(CNop, 2'd0, 13'd0, 16'h3333, 2'b00);
        drive(CNop, 2'd0, 13'd0, 16'h4444, 2'b00);
        for (int i = 0; i < 4; i++) expect_beat(i, 16'h1111 * 16'(i + 1));
        drive(CRd, 2'd1, 13'd8, 16'h0, 2'b00);
        idle(8);
        check_eq("t1_err", {28'd0, err_flags}, 32'd0);
        check_eq("t1_mode", {31'd0, mode_done}, 32'd1);

        // BL8 wrap: write at col 5, read from col 0
        drive(CMrs, 2'd0, 13'h033, 16'h0, 2'b00);
        drive(CWr, 2'd1, 13'd5, dat[0], 2'b00);
        for (int i = 1; i < 8; i++) drive(CNop, 2'd0, 13'd0, dat[i], 2'b00);
        for (int i = 0; i < 8; i++) expect_beat(i, dat[(i + 3) % 8]);
        drive(CRd, 2'd1, 13'd0, 16'h0, 2'b00);
        idle(12);

        // CL2 BL4: read interrupted by read, then BST
        drive(CMrs, 2'd0, 13'h022, 16'h0, 2'b00);
        cl = 2;
        expect_beat(0, 16'h1111);
        expect_beat(1, 16'h2222);
        drive(CRd, 2'd1, 13'd8, 16'h0, 2'b00);
        idle(1);
        for (int i = 0; i < 4; i++) expect_beat(i, dat[(i + 3) % 8]);
        drive(CRd, 2'd1, 13'd0, 16'h0, 2'b00);
        idle(8);
        expect_beat(0, dat[3]);
        expect_beat(1, dat[4]);
        drive(CRd, 2'd1, 13'd0, 16'h0, 2'b00);
        idle(1);
        drive(CBst, 2'd0, 13'd0, 16'h0, 2'b00);
        idle(8);

        // Byte masking, BL1 CL3
        drive(CMrs, 2'd0, 13'h030, 16'h0, 2'b00);
        cl = 3;
        drive(CWr, 2'd1, 13'd20, 16'h1234, 2'b00);
        drive(CWr, 2'd1, 13'd20, 16'hABCD, 2'b10);
        expect_beat(0, 16'h12CD);
        drive(CRd, 2'd1, 13'd20, 16'h0, 2'b00);
        drive(CWr, 2'd1, 13'd20, 16'h5678, 2'b01);
        expect_beat(0, 16'h56CD);
        drive(CRd, 2'd1, 13'd20, 16'h0, 2'b00);
        idle(6);

        // CKE stall mid-read, then auto-precharge
        drive(CMrs, 2'd0, 13'h032, 16'h0, 2'b00);
        for (int i = 0; i < 4; i++) expect_beat(i, 16'h1111 * 16'(i + 1));
        drive(CRd, 2'd1, 13'd8, 16'h0, 2'b00);
        idle(1);
        cke = 1'b0;
        idle(3);
        cke = 1'b1;
        idle(8);
        for (int i = 0; i < 4; i++) expect_beat(i, 16'h1111 * 16'(i + 1));
        drive(CRd, 2'd1, 13'h408, 16'h0, 2'b00);
        idle(8);
        check_eq("ap_err_before", {28'd0, err_flags}, 32'd0);
        drive(CRd, 2'd1, 13'd8, 16'h0, 2'b00);
        check_eq("ap_err_after", {28'd0, err_flags}, 32'd1);
        idle(8);

        // Error flags
        do_reset();
        check_eq("e_rst0", {28'd0, err_flags}, 32'd0);
        drive(CAct, 2'd0, 13'd1, 16'h0, 2'b00);
        check_eq("e_act_pre_mrs", {28'd0, err_flags}, 32'd4);
        check_eq("e_mode0", {31'd0, mode_done}, 32'd0);
        do_reset();
        check_eq("e_rst1", {28'd0, err_flags}, 32'd0);
        drive(CMrs, 2'd0, 13'h032, 16'h0, 2'b00);
        drive(CRd, 2'd2, 13'd0, 16'h0, 2'b00);
        check_eq("e_rd_closed", {28'd0, err_flags}, 32'd1);
        idle(8);
        drive(CAct, 2'd3, 13'd0, 16'h0, 2'b00);
        check_eq("e_act_once", {28'd0, err_flags}, 32'd1);
        drive(CAct, 2'd3, 13'd1, 16'h0, 2'b00);
        check_eq("e_act_twice", {28'd0, err_flags}, 32'd3);
        do_reset();
        check_eq("e_rst2", {28'd0, err_flags}, 32'd0);
        check_eq("e_mode_rst", {31'd0, mode_done}, 32'd0);
        idle(4);
        check_eq("queue_empty", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sdram_cmd_responder.md
Name: sdram_cmd_responder

Overview:
- Synthesizable SDRAM device emulator. It sits on the chip side of the SDRAM command bus and answers the SDRAM controller exactly as a device would.
- Decodes the CS/RAS/CAS/WE commands, tracks open rows per bank and honours the mode register (CAS latency, burst length).
- Stores write data in a small on-chip RAM and returns read data at the programmed latency.
- Used for in-FPGA loopback bring-up and closed-loop simulation of the controller path. Sticky protocol-error flags are provided.

Parameters:
- ROW_BITS, 2, low row-address bits used for the backing-RAM index.
- COL_BITS, 6, low column bits used for the index. RAM depth is 2^(2+ROW_BITS+COL_BITS) words × 16 bits.

Ports:
- clk  in  1  single clock, same as the SDRAM chip clock.
- rst  in  1  synchronous, active-high reset.
- sdram_cke  in  1  clock enable; low = freeze.
- sdram_cs_n  in  1  chip select.
- sdram_ras_n  in  1  row strobe.
- sdram_cas_n  in  1  column strobe.
- sdram_we_n  in  1  write enable.
- sdram_ba  in  2  bank address.
- sdram_addr  in  13  row/column/mode address.
- sdram_dqm  in  2  write byte mask, 1 = masked; [1] = dq[15:8].
- dq_in  in  16  data from the controller.
- dq_out  out  16  read data.
- dq_oe  out  1  drive enable for dq_out.
- mode_done  out  1  set once the first MRS has been accepted.
- err_flags  out  4  sticky: [0] RD/WR to a closed bank, [1] ACT to an open bank, [2] RD/WR/ACT before MRS, [3] reserved, always 0.

Behaviour:
- Reset: dq_out=0, dq_oe=0, mode_done=0, err_flags=0, all banks closed, burst idle, read pipeline flushed, CL=3, BL=1. RAM contents are not reset.
- CKE: sample cke each cycle. If cke=0, the command is ignored and all counters and pipelines hold; dq_out/dq_oe hold their values.
- Command decode {cs_n,ras_n,cas_n,we_n}:
  - 1xxx or 0111 = NOP.
  - 0011 = ACT.
  - 0101 = READ.
  - 0100 = WRITE.
  - 0010 = PRE.
  - 0001 = REF.
  - 0000 = MRS.
  - 0110 = BST.
- MRS:
  - addr[2:0] sets BL: 000→1, 001→2, 010→4, 011→8, 111→full page (512).
  - addr[6:4] sets CL: 010→2, 011→3. Any other CL value keeps the old CL.
  - mode_done←1.
- ACT: bank[ba] open←1, row[ba]←addr[12:0]. If the bank is already open: set err[1] and overwrite the row.
- PRE: addr[10]=1 closes all banks; otherwise closes bank ba. A PRE hitting the bank of an active burst terminates that burst.
- REF: no effect. REF with any bank open is accepted silently.
- Burst engine (states IDLE, WBURST, RBURST):
  - READ/WRITE latches bank, column = addr[8:0], and auto-precharge = addr[10]. Column 0 is addressed in the same cycle.
  - The column increments each cycle for BL cycles total. It wraps within the BL-aligned block: the low log2(BL) bits count, the upper bits are fixed. Full page wraps 511→0.
  - After the last beat the state returns to IDLE. With auto-precharge set, the bank closes on the last beat.
  - If the target bank is closed: set err[0] and ignore the whole command (no RAM access, no data).
- Termination:
  - A new READ/WRITE during a burst ends the old burst and starts the new one in the same cycle.
  - BST ends the burst. Read beats already addressed still emerge from the pipeline.
  - WRITE during RBURST also flushes the read pipeline, so dq_oe=0 from that cycle.
- Write beats: RAM[{bank,row[ROW_BITS-1:0],col[COL_BITS-1:0]}] is written with dq_in in the same cycle, byte lanes gated by dqm (dqm write latency 0). Columns above COL_BITS alias.
- Read beats: the column addressed in cycle T appears on dq_out with dq_oe=1 in cycle T+CL. This is a registered RAM read plus a (CL-1)-stage delay. dqm is ignored on reads. dq_oe=0 when no beat is due; dq_out then holds its last value.
- Read-after-write to the same address in the same or the next cycle returns the new data.
- Error flags clear only on rst.

Test Plan:
1. Reset, MRS addr=0x032 (CL3, BL4), ACT ba=1 row=2, WRITE ba=1 col=8 with dq_in 0x1111,0x2222,0x3333,0x4444, READ col=8 → dq_oe high exactly cycles T+3..T+6 with data 0x1111..0x4444. err_flags=0 and mode_done=1 throughout.
2. BL8 write at col=5 → beats land at cols 5,6,7,0,1,2,3,4. A BL8 read from col=0 returns the beat-4 data first.
3. CL2 MRS, READ BL4, second READ after 2 beats → 2 beats from the first, then 4 from the second, contiguous. BST during the second read's first beat → exactly 1 more beat.
4. WRITE with dqm=2'b10 and dq_in=0xABCD over an old word 0x1234 → readback 0x12CD.
5. READ to a closed bank → err[0]=1, dq_oe never asserts. ACT twice to the same bank → err[1]. ACT before any MRS (after reset) → err[2]. Then rst → all flags 0.
6. cke=0 for 3 cycles in the middle of a CL3 BL4 read → output beats stretch by 3 cycles with no data lost. READ with addr[10]=1 followed by READ to the same bank → err[0].
